nco_quad: RTL and testbench

NCO_QUAD -- requirements
Module: nco_quad

---
 rtl/nco_pkg.sv | 53 +++++
 rtl/nco_sin_rom.sv | 40 ++++
 rtl/nco_quad.sv | 169 ++++++++++++++++
 tb/tb_nco_quad.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared definitions for the quadrature NCO: default widths, control-word
// width, dither LFSR constants, quadrant encoding and the quarter-wave
// sine table generator.
package nco_pkg;

    localparam int ACC_W_DEF      = 24;
    localparam int OUT_W_DEF      = 10;
    localparam int LUT_AW_DEF     = 8;
    localparam int CTRL_SHIFT_DEF = 4;

    // Width of the signed loop-filter correction word
    localparam int CTRL_W = 12;

    // Dither LFSR: x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci
    // form, so the feedback taps sit at bit positions 0, 2, 3 and 5.
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Quadrant encoding taken from the two top phase bits
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

    // Odd quadrants walk the quarter-wave table backwards
    function automatic logic quad_mirror(input quad_t q);
        return (q == QUAD_1) || (q == QUAD_3);
    endfunction

    // The lower half-plane negates the table value
    function automatic logic quad_negate(input quad_t q);
        return (q == QUAD_2) || (q == QUAD_3);
    endfunction

    // Cosine leads sine by one quadrant
    function automatic quad_t quad_next(input quad_t q);
        return quad_t'(q + 2'd1);
    endfunction

    // Table entry k: the half-LSB phase offset keeps every entry strictly
    // positive and makes the mirrored half-wave line up exactly.
    function automatic int rom_entry(input int k, input int out_w, input int lut_aw);
        real amp;
        real ang;
        amp = real'((1 << (out_w - 1)) - 1);
        ang = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(1 << lut_aw);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/nco_sin_rom.sv
// Quarter-wave sine ROM with two registered read ports, one for the sine
// path and one for the cosine path. Entries are unsigned magnitudes.
module nco_sin_rom
    import nco_pkg::*;
#(
    parameter int OUT_W  = OUT_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              rd_en,
    input  logic [LUT_AW-1:0] addr_a,
    input  logic [LUT_AW-1:0] addr_b,
    output logic [OUT_W-1:0]  data_a,
    output logic [OUT_W-1:0]  data_b
);

    localparam int DEPTH = 1 << LUT_AW;

    logic [OUT_W-1:0] rom_tbl [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
        assign rom_tbl[k] = OUT_W'(rom_entry(k, OUT_W, LUT_AW));
    end

    // Registered reads for both ports; the read data holds when no sample is in stage 2
    // NOTE: only the read registers are reset; the table is constant, and
    // sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            data_a <= '0;
            data_b <= '0;
        end else if (rd_en) begin
            data_a <= rom_tbl[addr_a];
            data_b <= rom_tbl[addr_b];
        end
    end

endmodule

// File: rtl/nco_quad.sv
// Quadrature numerically controlled oscillator: control-word register,
// frequency-word register, phase accumulator with wrap pulse, and a
// three-stage sine/cosine output pipeline built on a shared quarter-wave ROM.
// Optional phase dither is enabled by defining NCO_DITHER_EN.
module nco_quad
    import nco_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int LUT_AW     = LUT_AW_DEF,
    parameter int CTRL_SHIFT = CTRL_SHIFT_DEF
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    EN,
    input  logic [ACC_W-1:0]        FCW_BASE,
    input  logic [CTRL_W-1:0]       D1,
    input  logic                    CTRL_VALID,
    output logic [ACC_W-1:0]        PHASE,
    output logic                    CARRY,
    output logic signed [OUT_W-1:0] SIN,
    output logic signed [OUT_W-1:0] COS,
    output logic                    OUT_VALID
);

    // Quadrant bits plus table address: the only phase bits the lookup needs
    localparam int IDX_W = LUT_AW + 2;

    logic [CTRL_W-1:0] ctrl_reg;
    logic [ACC_W-1:0]  ctrl_ext;
    logic [ACC_W-1:0]  fcw_reg;
    logic [ACC_W:0]    phase_sum;
    logic [IDX_W-1:0]  cap_next;
    logic [IDX_W-1:0]  cap_phase;
    logic              s1_valid;
    logic              s2_valid;
    quad_t             quad_sin;
    quad_t             quad_cos;
    quad_t             s2_quad_sin;
    quad_t             s2_quad_cos;
    logic [LUT_AW-1:0] lut_addr;
    logic [LUT_AW-1:0] addr_sin;
    logic [LUT_AW-1:0] addr_cos;
    logic [OUT_W-1:0]  rom_sin;
    logic [OUT_W-1:0]  rom_cos;

    // Sign-extended, scaled correction and the widened accumulator sum
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        ctrl_ext  = {{(ACC_W - CTRL_W){ctrl_reg[CTRL_W-1]}}, ctrl_reg} << CTRL_SHIFT;
        phase_sum = {1'b0, PHASE} + {1'b0, fcw_reg};
    end

    // Control register loads on CTRL_VALID; frequency word re-registers every cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctrl_reg <= '0;
            fcw_reg  <= '0;
        end else begin
            if (CTRL_VALID) begin
                ctrl_reg <= D1;
            end
            fcw_reg <= FCW_BASE + ctrl_ext;
        end
    end

    // Phase accumulator: steps on EN with a one-cycle wrap pulse, else holds
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PHASE <= '0;
            CARRY <= 1'b0;
        end else if (EN) begin
            PHASE <= phase_sum[ACC_W-1:0];
            CARRY <= phase_sum[ACC_W];
        end else begin
            CARRY <= 1'b0;
        end
    end

`ifdef NCO_DITHER_EN
    localparam int DITH_W = (ACC_W - IDX_W > LFSR_W) ? LFSR_W : (ACC_W - IDX_W);

    logic [LFSR_W-1:0] lfsr;
    logic [ACC_W-1:0]  dith_sum;

    // Dither LFSR steps once per accumulator step
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lfsr <= LFSR_SEED;
        end else if (EN) begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]};
        end
    end

    // Dither only disturbs the sub-address bits; PHASE itself is untouched
    always_comb begin
        dith_sum = PHASE + ACC_W'(lfsr[DITH_W-1:0]);
        cap_next = dith_sum[ACC_W-1 -: IDX_W];
    end
`else
    assign cap_next = PHASE[ACC_W-1 -: IDX_W];
`endif

    // Stage 1: capture the pre-increment phase of each EN step
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid  <= 1'b0;
            cap_phase <= '0;
        end else begin
            s1_valid <= EN;
            if (EN) begin
                cap_phase <= cap_next;
            end
        end
    end

    // Stage 2 address: split quadrant, mirror the address in odd quadrants
    always_comb begin
        quad_sin = quad_t'(cap_phase[IDX_W-1 -: 2]);
        quad_cos = quad_next(quad_sin);
        lut_addr = cap_phase[LUT_AW-1:0];
        addr_sin = quad_mirror(quad_sin) ? ~lut_addr : lut_addr;
        addr_cos = quad_mirror(quad_cos) ? ~lut_addr : lut_addr;
    end

    nco_sin_rom #(
        .OUT_W  (OUT_W),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .rd_en   (s1_valid),
        .addr_a  (addr_sin),
        .addr_b  (addr_cos),
        .data_a  (rom_sin),
        .data_b  (rom_cos)
    );

    // Stage 2 registers: carry the quadrants alongside the ROM read
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s2_valid    <= 1'b0;
            s2_quad_sin <= QUAD_0;
            s2_quad_cos <= QUAD_0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_quad_sin <= quad_sin;
                s2_quad_cos <= quad_cos;
            end
        end
    end

    // Stage 3: apply the half-plane sign and present the sample
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            SIN       <= '0;
            COS       <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= s2_valid;
            if (s2_valid) begin
                SIN <= quad_negate(s2_quad_sin) ? -$signed(rom_sin) : $signed(rom_sin);
                COS <= quad_negate(s2_quad_cos) ? -$signed(rom_cos) : $signed(rom_cos);
            end
        end
    end

endmodule

// File: tb/tb_nco_quad.sv
// Directed self-checking bench for nco_quad with default parameters:
// reset state, quarter-rate quadrature sequence and wrap pulse, asynchronous
// reset with samples in flight, EN gaps, control-word latency and the
// CTRL_VALID/EN overlap. A dither section is compiled in with NCO_DITHER_EN.
module tb_nco_quad;

    logic               CLK = 1'b0;
    logic               RESET_N = 1'b1;
    logic               EN = 1'b0;
    logic [23:0]        FCW_BASE = 24'h400000;
    logic [11:0]        D1 = 12'h000;
    logic               CTRL_VALID = 1'b0;
    logic [23:0]        PHASE;
    logic               CARRY;
    logic signed [9:0]  SIN;
    logic signed [9:0]  COS;
    logic               OUT_VALID;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    nco_quad dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .EN         (EN),
        .FCW_BASE   (FCW_BASE),
        .D1         (D1),
        .CTRL_VALID (CTRL_VALID),
        .PHASE      (PHASE),
        .CARRY      (CARRY),
        .SIN        (SIN),
        .COS        (COS),
        .OUT_VALID  (OUT_VALID)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int          sin_tbl [4] = '{2, 511, -2, -511};
    int          cos_tbl [4] = '{511, -2, -511, 2};
    logic [23:0] exp_phase;

    logic        gap_en  [9] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
    logic        gap_ov  [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
    logic [23:0] gap_ph  [9] = '{24'h400000, 24'h400000, 24'h400000, 24'h800000,
                                 24'h800000, 24'h800000, 24'h800000, 24'h800000,
                                 24'h800000};
    int          gap_sin [9] = '{0, 0, 2, 2, 2, 511, 511, 511, 511};
    int          gap_cos [9] = '{0, 0, 511, 511, 511, -2, -2, -2, -2};
    int          pulses;

    initial begin
        // Reset state
        #1 RESET_N = 1'b0;
        #10;
        check("rst_phase", PHASE, 0);
        check("rst_carry", CARRY, 0);
        check("rst_sin", SIN, 0);
        check("rst_cos", COS, 0);
        check("rst_valid", OUT_VALID, 0);

        // Release, let fcw_reg pick up 0x400000, then run EN continuously
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        check("idle_phase", PHASE, 0);
        check("idle_fcw", dut.fcw_reg, 24'h400000);
        EN = 1'b1;
        exp_phase = 24'h000000;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_phase = exp_phase + 24'h400000;
            check($sformatf("run_phase_%0d", i), PHASE, exp_phase);
            check($sformatf("run_carry_%0d", i), CARRY, (i % 4 == 0) ? 1 : 0);
            check($sformatf("run_valid_%0d", i), OUT_VALID, (i >= 3) ? 1 : 0);
            if (i >= 3) begin
                check($sformatf("run_sin_%0d", i), SIN, sin_tbl[(i - 3) % 4]);
                check($sformatf("run_cos_%0d", i), COS, cos_tbl[(i - 3) % 4]);
            end
        end

        // Asynchronous reset mid-cycle with a full pipeline
        #3;
        RESET_N = 1'b0;
        EN = 1'b0;
        #1;
        check("arst_phase", PHASE, 0);
        check("arst_carry", CARRY, 0);
        check("arst_sin", SIN, 0);
        check("arst_cos", COS, 0);
        check("arst_valid", OUT_VALID, 0);
        tick();
        RESET_N = 1'b1;
        tick();
        tick();

        // EN gap 1,0,0,1: holds during the gap, two samples, first from phase 0
        pulses = 0;
        for (int j = 0; j < 9; j++) begin
            EN = gap_en[j];
            tick();
            check($sformatf("gap_phase_%0d", j), PHASE, gap_ph[j]);
            check($sformatf("gap_carry_%0d", j), CARRY, 0);
            check($sformatf("gap_valid_%0d", j), OUT_VALID, gap_ov[j]);
            check($sformatf("gap_sin_%0d", j), SIN, gap_sin[j]);
            check($sformatf("gap_cos_%0d", j), COS, gap_cos[j]);
            if (OUT_VALID === 1'b1) pulses++;
        end
        EN = 1'b0;
        check("gap_pulses", pulses, 2);

        // Control-word path: two-cycle latency, sign extension and shift
        RESET_N = 1'b0;
        FCW_BASE = 24'h010000;
        D1 = 12'h000;
        #4;
        RESET_N = 1'b1;
        tick();
        check("fcw_base", dut.fcw_reg, 24'h010000);
        D1 = 12'h800;
        CTRL_VALID = 1'b1;
        tick();
        CTRL_VALID = 1'b0;
        check("fcw_neg_lat1", dut.fcw_reg, 24'h010000);
        tick();
        check("fcw_neg_lat2", dut.fcw_reg, 24'h008000);
        D1 = 12'h7FF;
        CTRL_VALID = 1'b1;
        tick();
        CTRL_VALID = 1'b0;
        check("fcw_pos_lat1", dut.fcw_reg, 24'h008000);
        tick();
        check("fcw_pos_lat2", dut.fcw_reg, 24'h017FF0);

        // CTRL_VALID together with EN: this step and the next use the old word
        D1 = 12'h000;
        CTRL_VALID = 1'b1;
        EN = 1'b1;
        tick();
        CTRL_VALID = 1'b0;
        check("ovl_phase_1", PHASE, 24'h017FF0);
        tick();
        check("ovl_phase_2", PHASE, 24'h02FFE0);
        tick();
        check("ovl_phase_3", PHASE, 24'h03FFE0);
        EN = 1'b0;
        tick();
        check("ovl_hold", PHASE, 24'h03FFE0);
        check("ovl_carry", CARRY, 0);

`ifdef NCO_DITHER_EN
        // Zero frequency: accumulator stays put while dither moves sub-address bits
        RESET_N = 1'b0;
        FCW_BASE = 24'h000000;
        #4;
        RESET_N = 1'b1;
        tick();
        EN = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("dith_phase_%0d", i), PHASE, 0);
            if (i >= 3) begin
                check($sformatf("dith_sin_%0d", i), (SIN == 10'sd2) || (SIN == 10'sd3), 1);
            end
        end
        EN = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
